// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - Opcode localparams. The top two opcode bits select the class; the low
//     two bits select the operation within the class.
//   - Class field constants (CLS_ARITH, CLS_REL, CLS_SHIFT).
//   - Shift mode encodings, equal to op_code[1:0] of the shift opcodes.
//   - state_t, the control FSM state.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [5:0] OP_NE  = 6'b100001;
  localparam logic [5:0] OP_LTU = 6'b100010;
  localparam logic [5:0] OP_LTS = 6'b100011;
  localparam logic [5:0] OP_SLL = 6'b110000;
  localparam logic [5:0] OP_SRL = 6'b110001;
  localparam logic [5:0] OP_SRA = 6'b110010;
  localparam logic [5:0] OP_ROR = 6'b110011;

  localparam logic [1:0] CLS_ARITH = 2'b01;
  localparam logic [1:0] CLS_REL   = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: combinational single-step shifter.
// The control FSM feeds its accumulator through this block once per BUSY
// cycle, so it only ever has to move the data by at most SHIFT_STEP bits.
// Ports:
//   data     in   WIDTH          value to shift
//   mode     in   2              SH_SLL / SH_SRL / SH_SRA / SH_ROR
//   amt      in   log2(STEP)+1   bits to shift this step (0..SHIFT_STEP)
//   result   out  WIDTH          shifted value
//   out_bit  out  1              last bit shifted/rotated out (0 if amt = 0);
//                                for ROR this is result[WIDTH-1]
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic [WIDTH-1:0]            data,
  input  logic [1:0]                  mode,
  input  logic [$clog2(SHIFT_STEP):0] amt,
  output logic [WIDTH-1:0]            result,
  output logic                        out_bit
);

  // One guard bit beyond the data catches the last bit shifted out:
  // above the MSB for left shifts, below the LSB for right shifts.
  logic [WIDTH:0] ext;

  always_comb begin
    ext     = '0;
    result  = data;
    out_bit = 1'b0;
    case (mode)
      SH_SLL: begin
        ext     = {1'b0, data} << amt;
        result  = ext[WIDTH-1:0];
        out_bit = ext[WIDTH];
      end
      SH_SRL: begin
        ext     = {data, 1'b0} >> amt;
        result  = ext[WIDTH:1];
        out_bit = ext[0];
      end
      SH_SRA: begin
        ext     = $signed({data, 1'b0}) >>> amt;
        result  = ext[WIDTH:1];
        out_bit = ext[0];
      end
      default: begin
        // ROR; a shift by WIDTH (amt = 0) yields 0, so the OR is still exact.
        result  = (data >> amt) | (data << (WIDTH - int'(amt)));
        out_bit = result[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU.
// Arithmetic and relational ops finish in one registered cycle; shifts and
// rotates iterate SHIFT_STEP bits per BUSY cycle through alu_shift_step.
// Optional feature macro: ALU_SEQ_OVF_EN enables the signed-overflow flag v
// for ADD/SUB; without it v is constantly 0.
// Handshake: an op is taken when in_valid && in_ready (in_ready is high only
// in IDLE and never during reset). A result is presented with out_valid and
// every output held stable until out_valid && out_ready; then the block
// returns to IDLE, so a new op is accepted no earlier than the next cycle.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   issue handshake
//   op_code, a, b    operation and operands (shift amount = b[log2(WIDTH)-1:0])
//   c_in             carry-in (ADD) / borrow-in (SUB)
//   out_valid/ready  result handshake
//   ans              result
//   c_out            carry / borrow / last bit shifted out
//   z, n, v, err     zero, negative, signed overflow, illegal opcode
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             c_out,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int AW = $clog2(SHIFT_STEP) + 1;
  localparam int EW = WIDTH + 1;

  state_t state, next_state;

  logic [WIDTH-1:0] acc;   // shift accumulator
  logic [SW-1:0]    rem;   // bits still to shift
  logic [1:0]       mode;  // captured shift mode

  logic [SW-1:0]    amt_in;
  logic             accept;
  logic             legal;
  logic             shift_nz;

  logic [EW-1:0]    sum_ext;
  logic [EW-1:0]    diff_ext;
  logic [WIDTH-1:0] imm_ans;
  logic             imm_c;
  logic             imm_v;
  logic             imm_err;

  logic [AW-1:0]    step;
  logic             last_step;
  logic [WIDTH-1:0] sh_res;
  logic             sh_bit;

  assign amt_in = b[SW-1:0];
  assign accept = in_valid && in_ready;

  always_comb begin
    legal = 1'b0;
    case (op_code)
      OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LTU, OP_LTS,
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Zero-amount shifts skip BUSY and finish like a one-cycle op.
  assign shift_nz = legal && (op_code[5:4] == CLS_SHIFT) && (amt_in != '0);

  // Single-cycle result, used for everything that does not enter BUSY.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b} + EW'(c_in);
    // The extra top bit of the difference is the unsigned borrow.
    diff_ext = {1'b0, a} - {1'b0, b} - EW'(c_in);
    imm_ans  = '0;
    imm_c    = 1'b0;
    imm_v    = 1'b0;
    imm_err  = 1'b0;
    case (op_code)
      OP_ADD: begin
        imm_ans = sum_ext[WIDTH-1:0];
        imm_c   = sum_ext[WIDTH];
`ifdef ALU_SEQ_OVF_EN
        imm_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
`endif
      end
      OP_SUB: begin
        imm_ans = diff_ext[WIDTH-1:0];
        imm_c   = diff_ext[WIDTH];
`ifdef ALU_SEQ_OVF_EN
        imm_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
`endif
      end
      OP_EQ:  imm_ans = WIDTH'(a == b);
      OP_NE:  imm_ans = WIDTH'(a != b);
      OP_LTU: imm_ans = WIDTH'(a < b);
      OP_LTS: imm_ans = WIDTH'($signed(a) < $signed(b));
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: imm_ans = a;  // only reached with amount 0
      default: imm_err = 1'b1;
    endcase
  end

  // Per-cycle step size: min(rem, SHIFT_STEP).
  always_comb begin
    if (int'(rem) > SHIFT_STEP) begin
      step      = AW'(SHIFT_STEP);
      last_step = 1'b0;
    end else begin
      step      = AW'(rem);
      last_step = 1'b1;
    end
  end

  alu_shift_step #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_step (
    .data    (acc),
    .mode    (mode),
    .amt     (step),
    .result  (sh_res),
    .out_bit (sh_bit)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) next_state = shift_nz ? BUSY : DONE;
      end
      BUSY: begin
        if (last_step) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and result registers. Results only change on the way into DONE,
  // so they stay put through DONE and keep their value in IDLE/BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      rem   <= '0;
      mode  <= '0;
      ans   <= '0;
      c_out <= 1'b0;
      z     <= 1'b0;
      n     <= 1'b0;
      v     <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (shift_nz) begin
              acc  <= a;
              rem  <= amt_in;
              mode <= op_code[1:0];
            end else begin
              ans   <= imm_ans;
              c_out <= imm_c;
              z     <= (imm_ans == '0);
              n     <= imm_ans[WIDTH-1];
              v     <= imm_v;
              err   <= imm_err;
            end
          end
        end
        BUSY: begin
          acc <= sh_res;
          rem <= rem - SW'(step);
          if (last_step) begin
            ans   <= sh_res;
            c_out <= sh_bit;
            z     <= (sh_res == '0);
            n     <= sh_res[WIDTH-1];
            v     <= 1'b0;
            err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=32, SHIFT_STEP=1).
// Expected results come from a plain-arithmetic reference model; the
// expected-result queue holds each op's answer from issue until it is seen.
module tb_alu_seq;

  localparam int W    = 32;
  localparam int STEP = 1;

  localparam logic [5:0] T_ADD = 6'b010000;
  localparam logic [5:0] T_SUB = 6'b010001;
  localparam logic [5:0] T_EQ  = 6'b100000;
  localparam logic [5:0] T_NE  = 6'b100001;
  localparam logic [5:0] T_LTU = 6'b100010;
  localparam logic [5:0] T_LTS = 6'b100011;
  localparam logic [5:0] T_SLL = 6'b110000;
  localparam logic [5:0] T_SRL = 6'b110001;
  localparam logic [5:0] T_SRA = 6'b110010;
  localparam logic [5:0] T_ROR = 6'b110011;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   op_code;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ans;
  logic         c_out;
  logic         z;
  logic         n;
  logic         v;
  logic         err;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans       (ans),
    .c_out     (c_out),
    .z         (z),
    .n         (n),
    .v         (v),
    .err       (err)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  logic [5:0] legal_ops[10] = '{T_ADD, T_SUB, T_EQ, T_NE, T_LTU, T_LTS,
                                T_SLL, T_SRL, T_SRA, T_ROR};
  logic [5:0] bad_ops[6]    = '{6'b000000, 6'b010010, 6'b100100,
                                6'b110100, 6'b111111, 6'b001101};

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic [5:0] op, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic ci,
                                output logic [W-1:0] r, output logic co,
                                output logic vo, output logic eo, output int lat);
    int k;
    longint s;
    longint unsigned u;
    k   = int'(y[4:0]);
    r   = '0;
    co  = 1'b0;
    vo  = 1'b0;
    eo  = 1'b0;
    lat = 1;
    case (op)
      T_ADD: begin
        u  = longint'(x) + longint'(y) + longint'(ci);
        r  = u[31:0];
        co = u[32];
        s  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
`ifdef ALU_SEQ_OVF_EN
        vo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
      end
      T_SUB: begin
        r  = x - y - W'(ci);
        co = longint'(x) < (longint'(y) + longint'(ci));
        s  = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
`ifdef ALU_SEQ_OVF_EN
        vo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
      end
      T_EQ:  r = (x == y) ? 1 : 0;
      T_NE:  r = (x != y) ? 1 : 0;
      T_LTU: r = (x < y) ? 1 : 0;
      T_LTS: r = ($signed(x) < $signed(y)) ? 1 : 0;
      T_SLL, T_SRL, T_SRA, T_ROR: begin
        if (k == 0) begin
          r = x;
        end else begin
          lat = 1 + (k + STEP - 1) / STEP;
          case (op)
            T_SLL: begin r = x << k; co = x[W-k]; end
            T_SRL: begin r = x >> k; co = x[k-1]; end
            T_SRA: begin r = $signed(x) >>> k; co = x[k-1]; end
            default: begin r = (x >> k) | (x << (W - k)); co = r[W-1]; end
          endcase
        end
      end
      default: eo = 1'b1;
    endcase
  endfunction

  // ---------------- driver: one full transaction ----------------
  task automatic run_op(input string name, input logic [5:0] op,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input int stall);
    logic [W-1:0] er;
    logic [W-1:0] got_exp;
    logic ec, ev, ee;
    int lat, cyc, guard;
    model(op, x, y, ci, er, ec, ev, ee, lat);
    exp_q.push_back(er);

    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_ready got=%b exp=1", name, in_ready);
    end

    in_valid = 1'b1; op_code = op; a = x; b = y; c_in = ci; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op_code = 6'($urandom); a = $urandom; b = $urandom;
    c_in = 1'($urandom_range(0, 1));

    cyc = 1;
    while (!out_valid && cyc < 200) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s busy_in_ready cyc=%0d got=%b exp=0", name, cyc, in_ready);
      end
      @(posedge clk); #1; cyc++;
    end

    got_exp = exp_q.pop_front();
    checks++;
    if (cyc !== lat || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d out_valid=%b", name, cyc, lat, out_valid);
    end
    checks++;
    if (ans !== got_exp || c_out !== ec || err !== ee) begin
      failures++;
      $display("FAIL %s result op=%b a=%h b=%h ci=%b got ans=%h c=%b err=%b exp ans=%h c=%b err=%b",
               name, op, x, y, ci, ans, c_out, err, got_exp, ec, ee);
    end
    checks++;
    if (z !== (got_exp == '0) || n !== got_exp[W-1] || v !== ev) begin
      failures++;
      $display("FAIL %s flags got z=%b n=%b v=%b exp z=%b n=%b v=%b",
               name, z, n, v, (got_exp == '0), got_exp[W-1], ev);
    end

    // Backpressure: hold out_ready low and offer a competing op.
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; op_code = T_ADD; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ans !== got_exp || c_out !== ec ||
          err !== ee || z !== (got_exp == '0)) begin
        failures++;
        $display("FAIL %s stall%0d got ov=%b ir=%b ans=%h c=%b exp ov=1 ir=0 ans=%h c=%b",
                 name, i, out_valid, in_ready, ans, c_out, got_exp, ec);
      end
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release got ov=%b ir=%b exp ov=0 ir=1", name, out_valid, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_code = '0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || ans !== '0 || c_out !== 1'b0 || z !== 1'b0 ||
        n !== 1'b0 || v !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got ov=%b ans=%h c=%b z=%b n=%b v=%b err=%b ir=%b exp all 0",
               out_valid, ans, c_out, z, n, v, err, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_arith();
    run_op("add_wrap", T_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op("sub_borrow", T_SUB, 32'd5, 32'd7, 1'b0, 0);
    run_op("add_ovf", T_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 0);
    run_op("add_cin", T_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b1, 0);
    run_op("sub_bin", T_SUB, 32'd8, 32'd7, 1'b1, 0);
    run_op("sub_ovf", T_SUB, 32'h8000_0000, 32'd1, 1'b0, 0);
  endtask

  task automatic test_relational();
    run_op("lts_neg", T_LTS, 32'h8000_0000, 32'd1, 1'b0, 0);
    run_op("ltu_neg", T_LTU, 32'h8000_0000, 32'd1, 1'b0, 0);
    run_op("eq_same", T_EQ, 32'h1234, 32'h1234, 1'b0, 0);
    run_op("ne_same", T_NE, 32'h1234, 32'h1234, 1'b0, 0);
  endtask

  task automatic test_shift();
    run_op("sra_4", T_SRA, 32'h8000_0000, 32'd4, 1'b0, 0);
    run_op("sll_0", T_SLL, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
    run_op("sll_31", T_SLL, 32'h0000_0003, 32'd31, 1'b0, 0);
    run_op("srl_1", T_SRL, 32'h0000_0001, 32'h0000_0021, 1'b0, 0);
    run_op("ror_8", T_ROR, 32'h1234_5678, 32'd8, 1'b0, 0);
    run_op("ror_31", T_ROR, 32'h0000_0001, 32'd31, 1'b0, 0);
  endtask

  task automatic test_illegal_backpressure();
    run_op("illegal_0", 6'b000000, 32'hAAAA_5555, 32'h1, 1'b1, 3);
    run_op("illegal_3f", 6'b111111, 32'h1, 32'h2, 1'b0, 0);
    run_op("stall_sub", T_SUB, 32'd5, 32'd7, 1'b0, 3);
    run_op("stall_sra", T_SRA, 32'hF000_0001, 32'd3, 1'b0, 2);
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic [W-1:0] x, y;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 5)];
      else                           op = legal_ops[$urandom_range(0, 9)];
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 4) == 0) y = x;
      if ($urandom_range(0, 5) == 0) y = '0;
      run_op("random", op, x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    logic [W-1:0] x, y, er, got_exp;
    logic ci, ec, ev, ee;
    int lat;
    out_ready = 1'b1;
    op = legal_ops[$urandom_range(0, 5)]; x = $urandom; y = $urandom; ci = 1'($urandom_range(0, 1));
    model(op, x, y, ci, er, ec, ev, ee, lat);
    exp_q.push_back(er);
    in_valid = 1'b1; op_code = op; a = x; b = y; c_in = ci;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      got_exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ans !== got_exp || c_out !== ec) begin
        failures++;
        $display("FAIL b2b_result%0d got ov=%b ir=%b ans=%h c=%b exp ov=1 ir=0 ans=%h c=%b",
                 i, out_valid, in_ready, ans, c_out, got_exp, ec);
      end
      // Next op is offered in the DONE cycle and must wait for IDLE.
      if (i < 5) begin
        op = legal_ops[$urandom_range(0, 5)]; x = $urandom; y = $urandom;
        ci = 1'($urandom_range(0, 1));
        model(op, x, y, ci, er, ec, ev, ee, lat);
        exp_q.push_back(er);
        op_code = op; a = x; b = y; c_in = ci;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gap%0d got ov=%b ir=%b exp ov=0 ir=1", i, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    // Leave non-zero results behind so the reset clearing is visible.
    run_op("pre_reset", T_SUB, 32'd5, 32'd7, 1'b0, 0);
    in_valid = 1'b1; op_code = T_ROR; a = 32'hCAFE_F00D; b = 32'd20; c_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_before_reset got ov=%b ir=%b exp ov=0 ir=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || ans !== '0 || c_out !== 1'b0 || z !== 1'b0 ||
        n !== 1'b0 || v !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_reset_values got ov=%b ans=%h c=%b z=%b n=%b v=%b err=%b ir=%b exp all 0",
               out_valid, ans, c_out, z, n, v, err, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_reset_ready got=%b exp=1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || ans !== '0) begin
      failures++;
      $display("FAIL aborted_result_emitted got valid_cycles=%0d ans=%h exp 0 and 0", seen, ans);
    end
    run_op("after_reset", T_ADD, 32'd40, 32'd2, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_relational();
    test_shift();
    test_illegal_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
